// File: rtl/i2si_bist_pkg.sv
// ============================================================================
// Module      : i2si_bist_pkg
// Description : Shared state encoding, error codes and sawtooth helper for
//               the I2S-input BIST controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2si_bist_pkg;

  localparam int DATA_W = 32;
  localparam int VAL_W  = 12;
  localparam int INC_W  = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CFG  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_CFG  = 2'd1,
    ERR_SEQ  = 2'd2,
    ERR_TO   = 2'd3
  } bist_err_e;

  // Next ramp value: wrap to the start value once the limit has been reached.
  function automatic logic [DATA_W-1:0] saw_next(
    input logic [DATA_W-1:0] prev,
    input logic [VAL_W-1:0]  start_val,
    input logic [INC_W-1:0]  inc,
    input logic [VAL_W-1:0]  up_limit
  );
    if (prev >= DATA_W'(up_limit)) return DATA_W'(start_val);
    return prev + DATA_W'(inc);
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2si_bist_chk.sv
// ============================================================================
// Module      : i2si_bist_chk
// Description : Sample detection, expected-ramp compare and inactivity
//               watchdog for the I2S-input BIST run.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2si_bist_chk
  import i2si_bist_pkg::*;
#(
  parameter int              TO_W   = 16,
  parameter logic [TO_W-1:0] TO_CYC = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_run,
  input  logic [DATA_W-1:0] i_data,
  input  logic [VAL_W-1:0]  i_start_val,
  input  logic [INC_W-1:0]  i_inc,
  input  logic [VAL_W-1:0]  i_up_limit,
  output logic              o_mismatch,
  output logic              o_timeout
);

  localparam logic [TO_W-1:0] c_WD_LAST = TO_CYC - 1'b1;

  logic [DATA_W-1:0] r_prev;
  logic              r_first;
  logic [TO_W-1:0]   r_wd;

  logic              w_new;
  logic [DATA_W-1:0] w_exp;

  // Until the first sample is seen, only the start value counts as a sample.
  assign w_new = r_first ? (i_data == DATA_W'(i_start_val)) : (i_data != r_prev);
  assign w_exp = saw_next(r_prev, i_start_val, i_inc, i_up_limit);

  assign o_mismatch = i_run & ~r_first & w_new & (i_data != w_exp);
  assign o_timeout  = i_run & ~w_new & (r_wd >= c_WD_LAST);

  always_ff @(posedge clk) begin
    if (rst || !i_run) begin
      r_prev  <= '0;
      r_first <= 1'b1;
      r_wd    <= '0;
    end else if (w_new) begin
      r_prev  <= i_data;
      r_first <= 1'b0;
      r_wd    <= '0;
    end else if (r_wd != TO_CYC) begin
      r_wd <= r_wd + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/i2si_bist_ctrl.sv
// ============================================================================
// Module      : i2si_bist_ctrl
// Description : Sequences the I2S-input BIST sawtooth generator, counts
//               periods and reports busy/done/pass/error status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2si_bist_ctrl
  import i2si_bist_pkg::*;
#(
  parameter int              PER_W  = 8,
  parameter int              TO_W   = 16,
  parameter logic [TO_W-1:0] TO_CYC = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rf_bist_en,
  input  logic [VAL_W-1:0]  rf_bist_start_val,
  input  logic [INC_W-1:0]  rf_bist_inc,
  input  logic [VAL_W-1:0]  rf_bist_up_limit,
  input  logic [PER_W-1:0]  rf_bist_periods,
  input  logic [DATA_W-1:0] gen_data,
  input  logic              gen_xfc,
  output logic              gen_rst_n,
  output logic [VAL_W-1:0]  gen_start_val,
  output logic [INC_W-1:0]  gen_inc,
  output logic [VAL_W-1:0]  gen_up_limit,
  output logic              i2si_bist_sel,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_pass,
  output logic [1:0]        bist_err,
  output logic [PER_W-1:0]  bist_per_cnt
);

  localparam logic [PER_W-1:0] c_PER_ONE = 1;

  logic [1:0]       r_state;
  logic             r_en_q;
  logic             r_xfc_q;
  logic [VAL_W-1:0] r_start_val;
  logic [INC_W-1:0] r_inc;
  logic [VAL_W-1:0] r_up_limit;
  logic [PER_W-1:0] r_periods;
  logic [PER_W-1:0] r_per_cnt;
  logic             r_gen_rst_n;
  logic             r_sel;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  bist_err_e        r_err;

  logic w_start;
  logic w_xfc_rise;
  logic w_cfg_bad;
  logic w_last_per;
  logic w_abort;
  logic w_mismatch;
  logic w_timeout;

  assign w_start    = rf_bist_en & ~r_en_q;
  assign w_xfc_rise = gen_xfc & ~r_xfc_q;
  assign w_cfg_bad  = (r_inc == '0) || (r_start_val >= r_up_limit) || (r_periods == '0);
  assign w_last_per = w_xfc_rise && ((r_per_cnt + c_PER_ONE) == r_periods);
  assign w_abort    = ((r_state == S_CFG) || (r_state == S_RUN)) && !rf_bist_en;

  i2si_bist_chk #(
    .TO_W   (TO_W),
    .TO_CYC (TO_CYC)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .i_run       (r_state == S_RUN),
    .i_data      (gen_data),
    .i_start_val (r_start_val),
    .i_inc       (r_inc),
    .i_up_limit  (r_up_limit),
    .o_mismatch  (w_mismatch),
    .o_timeout   (w_timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_en_q      <= 1'b0;
      r_xfc_q     <= 1'b0;
      r_start_val <= '0;
      r_inc       <= '0;
      r_up_limit  <= '0;
      r_periods   <= '0;
      r_per_cnt   <= '0;
      r_gen_rst_n <= 1'b0;
      r_sel       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err       <= ERR_NONE;
    end else begin
      r_en_q  <= rf_bist_en;
      r_xfc_q <= gen_xfc;
      if (w_abort) begin
        r_state     <= S_IDLE;
        r_gen_rst_n <= 1'b0;
        r_sel       <= 1'b0;
        r_busy      <= 1'b0;
        r_done      <= 1'b0;
        r_pass      <= 1'b0;
        r_err       <= ERR_NONE;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_gen_rst_n <= 1'b0;
            r_sel       <= 1'b0;
            if (w_start) begin
              r_start_val <= rf_bist_start_val;
              r_inc       <= rf_bist_inc;
              r_up_limit  <= rf_bist_up_limit;
              r_periods   <= rf_bist_periods;
              r_per_cnt   <= '0;
              r_busy      <= 1'b1;
              r_done      <= 1'b0;
              r_pass      <= 1'b0;
              r_err       <= ERR_NONE;
              r_state     <= S_CFG;
            end
          end
          S_CFG: begin
            if (w_cfg_bad) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_err   <= ERR_CFG;
            end else begin
              r_state     <= S_RUN;
              r_gen_rst_n <= 1'b1;
              r_sel       <= 1'b1;
            end
          end
          S_RUN: begin
            if (w_xfc_rise && (r_per_cnt != r_periods)) r_per_cnt <= r_per_cnt + c_PER_ONE;
            // A bad sample outranks a timeout, which outranks the final period edge.
            if (w_mismatch || w_timeout || w_last_per) begin
              r_state     <= S_DONE;
              r_gen_rst_n <= 1'b0;
              r_sel       <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_pass      <= !w_mismatch && !w_timeout;
              r_err       <= w_mismatch ? ERR_SEQ : (w_timeout ? ERR_TO : ERR_NONE);
            end
          end
          S_DONE: begin
            if (!rf_bist_en) begin
              r_state <= S_IDLE;
              r_done  <= 1'b0;
              r_pass  <= 1'b0;
              r_err   <= ERR_NONE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign gen_rst_n     = r_gen_rst_n;
  assign gen_start_val = r_start_val;
  assign gen_inc       = r_inc;
  assign gen_up_limit  = r_up_limit;
  assign i2si_bist_sel = r_sel;
  assign bist_busy     = r_busy;
  assign bist_done     = r_done;
  assign bist_pass     = r_pass;
  assign bist_err      = r_err;
  assign bist_per_cnt  = r_per_cnt;

endmodule

`default_nettype wire
